// File: rtl/rect_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rect_fill_pkg
// Description : Shared types and constants for the rectangle filler: FSM
//               state encoding, burst geometry and the address split helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rect_fill_pkg;

  // Fill sequencer states: idle, first/second data beat of a burst, completion
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int         PIX_PER_BEAT = 4;
  localparam int         BEATS        = 2;
  localparam int         BURST_PIX    = 8;
  localparam logic [7:0] PIXEL_PAD    = 8'h00;

  // Lowest frame_base bit that survives into the burst address; everything
  // below it is replaced by {y, xb, 2'b00}.
  function automatic int addr_lo(input int x_w, input int y_w);
    return y_w + (x_w - 3) + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rect_filler_if.sv
`default_nettype none
// ============================================================================
// Module      : rect_filler_if
// Description : Command handshake plus MIG af/wdf write port of the
//               rectangle filler, grouped as one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rect_filler_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           valid;
  logic           ready;
  logic [23:0]    color;
  logic [X_W-1:0] x0;
  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y0;
  logic [Y_W-1:0] y1;
  logic [31:0]    frame_base;
  logic           af_full;
  logic           wdf_full;
  logic           af_wr_en;
  logic [30:0]    af_addr_din;
  logic           wdf_wr_en;
  logic [127:0]   wdf_din;
  logic [15:0]    wdf_mask_din;
  logic           done;

  // Filler side
  modport slave (
    input  valid, color, x0, x1, y0, y1, frame_base, af_full, wdf_full,
    output ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din, done
  );

  // Command processor / memory controller side
  modport master (
    output valid, color, x0, x1, y0, y1, frame_base, af_full, wdf_full,
    input  ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din, done
  );
endinterface
`default_nettype wire

// File: rtl/rect_fill_mask.sv
`default_nettype none
// ============================================================================
// Module      : rect_fill_mask
// Description : Byte mask for one 4-pixel beat; a pixel outside [x0, x1]
//               gets all four of its bytes masked (1 = not written).
// Revision    : 1.0 - initial release
// ============================================================================
module rect_fill_mask
  import rect_fill_pkg::*;
#(
  parameter int X_W = 10
) (
  input  wire logic [X_W-1:0]            beat_x_i,
  input  wire logic [X_W-1:0]            x0_i,
  input  wire logic [X_W-1:0]            x1_i,
  output logic [4*PIX_PER_BEAT-1:0]      mask_o
);

  // One extra bit so beat_x + 3 can never wrap back inside the rectangle
  for (genvar p = 0; p < PIX_PER_BEAT; p++) begin : g_pix
    logic [X_W:0] w_px;
    assign w_px = {1'b0, beat_x_i} + (X_W+1)'(p);
    assign mask_o[4*p +: 4] = ((w_px < {1'b0, x0_i}) || (w_px > {1'b0, x1_i}))
                              ? 4'hF : 4'h0;
  end

endmodule
`default_nettype wire

// File: rtl/rect_filler.sv
`default_nettype none
// ============================================================================
// Module      : rect_filler
// Description : Fills an inclusive rectangle of a DDR2 frame buffer with one
//               colour, one af command plus two wdf beats per 8-pixel burst.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_filler
  import rect_fill_pkg::*;
#(
  parameter int FRAME_W = 800,
  parameter int FRAME_H = 600,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
) (
  input  wire logic    clk,
  input  wire logic    rst,
  rect_filler_if.slave bus
);

  localparam int             XB_W    = X_W - 3;
  localparam int             ADDR_LO = addr_lo(X_W, Y_W);
  localparam logic [X_W-1:0] C_X_MAX = X_W'(FRAME_W - 1);
  localparam logic [Y_W-1:0] C_Y_MAX = Y_W'(FRAME_H - 1);

  state_e                state_q, state_d;
  logic [XB_W-1:0]       xb_q, xb_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [X_W-1:0]        x0_q, x1_q;
  logic [Y_W-1:0]        y1_q;
  logic [23:0]           color_q;
  logic [30-ADDR_LO:0]   base_q;

  logic [X_W-1:0]        w_x1_clamp;
  logic [Y_W-1:0]        w_y1_clamp;
  logic                  w_accept;
  logic                  w_af_push;
  logic                  w_wdf_push;
  logic [X_W-1:0]        w_beat_x;
  logic                  w_unused_base;

  assign w_x1_clamp = (bus.x1 > C_X_MAX) ? C_X_MAX : bus.x1;
  assign w_y1_clamp = (bus.y1 > C_Y_MAX) ? C_Y_MAX : bus.y1;
  assign w_accept   = (state_q == IDLE) && bus.valid;

  // Low frame_base bits are overwritten by the pixel coordinates
  assign w_unused_base = ^{bus.frame_base[31], bus.frame_base[ADDR_LO-1:0]};

  // Sequencer state and burst position
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xb_q    <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      xb_q    <= xb_d;
      y_q     <= y_d;
    end
  end

  // Command operands, captured on accept with the bounds already clamped
  always_ff @(posedge clk) begin
    if (w_accept) begin
      x0_q    <= bus.x0;
      x1_q    <= w_x1_clamp;
      y1_q    <= w_y1_clamp;
      color_q <= bus.color;
      base_q  <= bus.frame_base[30:ADDR_LO];
    end
  end

  // Next state, raster walk and FIFO push decisions
  always_comb begin
    state_d    = state_q;
    xb_d       = xb_q;
    y_d        = y_q;
    w_af_push  = 1'b0;
    w_wdf_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          if ((bus.x0 > w_x1_clamp) || (bus.y0 > w_y1_clamp)) begin
            state_d = DONE;
          end else begin
            state_d = BEAT0;
            xb_d    = bus.x0[X_W-1:3];
            y_d     = bus.y0;
          end
        end
      end
      BEAT0: begin
        if (!bus.af_full && !bus.wdf_full) begin
          w_af_push  = 1'b1;
          w_wdf_push = 1'b1;
          state_d    = BEAT1;
        end
      end
      BEAT1: begin
        if (!bus.wdf_full) begin
          w_wdf_push = 1'b1;
          if (xb_q < x1_q[X_W-1:3]) begin
            xb_d    = xb_q + XB_W'(1);
            state_d = BEAT0;
          end else if (y_q < y1_q) begin
            y_d     = y_q + Y_W'(1);
            xb_d    = x0_q[X_W-1:3];
            state_d = BEAT0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // First pixel of the current beat: lanes 0..3 in BEAT0, 4..7 in BEAT1
  assign w_beat_x = {xb_q, (state_q == BEAT1), 2'b00};

  rect_fill_mask #(
    .X_W (X_W)
  ) u_mask (
    .beat_x_i (w_beat_x),
    .x0_i     (x0_q),
    .x1_i     (x1_q),
    .mask_o   (bus.wdf_mask_din)
  );

  // Pushes are suppressed while reset is held so an abandoned fill emits nothing
  assign bus.af_wr_en    = w_af_push & ~rst;
  assign bus.wdf_wr_en   = w_wdf_push & ~rst;
  assign bus.af_addr_din = {base_q, y_q, xb_q, 2'b00};
  assign bus.wdf_din     = {4{PIXEL_PAD, color_q}};
  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_rect_filler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rect_filler
// Description : Scoreboard bench for rect_filler; a pixel-level reference
//               model queues expected af/wdf traffic, a monitor checks it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_filler;

  localparam int FW = 800;
  localparam int FH = 600;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  mask;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rect_filler_if #(.X_W(10), .Y_W(10)) bus ();

  rect_filler #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .X_W     (10),
    .Y_W     (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [30:0] af_q[$];
  beat_t       wdf_q[$];
  int checks = 0;
  int failures = 0;
  int done_expected = 0;
  int done_seen = 0;
  int af_pushes = 0;
  int wdf_pushes = 0;
  int bp_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk every covered burst of the clamped rectangle pixel by pixel
  task automatic model_cmd(input logic [23:0] col, input int x0, input int x1,
                           input int y0, input int y1, input logic [31:0] base);
    int x1c;
    int y1c;
    x1c = (x1 > FW-1) ? FW-1 : x1;
    y1c = (y1 > FH-1) ? FH-1 : y1;
    if (x0 > x1c || y0 > y1c) return;
    for (int y = y0; y <= y1c; y++) begin
      for (int b = x0 / 8; b <= x1c / 8; b++) begin
        af_q.push_back(31'((base & 32'h7FF8_0000) + 32'(y * 512) + 32'(b * 4)));
        for (int k = 0; k < 2; k++) begin
          beat_t e;
          e.data = {4{8'h00, col}};
          e.mask = '0;
          for (int p = 0; p < 4; p++) begin
            int px;
            px = b * 8 + k * 4 + p;
            if (px < x0 || px > x1c) e.mask[4*p +: 4] = 4'hF;
          end
          wdf_q.push_back(e);
        end
      end
    end
  endtask

  // FIFO full flags: clear, or randomly toggled each cycle
  initial begin
    bus.af_full  = 1'b0;
    bus.wdf_full = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bp_mode != 0) begin
        bus.af_full  = ($urandom_range(0, 2) == 0);
        bus.wdf_full = ($urandom_range(0, 2) == 0);
      end else begin
        bus.af_full  = 1'b0;
        bus.wdf_full = 1'b0;
      end
    end
  end

  // Monitor: compare every push and every done against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.af_wr_en) begin
        af_pushes++;
        check("af_while_full", bus.af_full, 1'b0);
        if (af_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL af_extra: got push addr %0h expected no push", bus.af_addr_din);
        end else begin
          check("af_addr", bus.af_addr_din, af_q.pop_front());
        end
      end
      if (bus.wdf_wr_en) begin
        wdf_pushes++;
        check("wdf_while_full", bus.wdf_full, 1'b0);
        if (wdf_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wdf_extra: got push mask %0h expected no push", bus.wdf_mask_din);
        end else begin
          beat_t e;
          e = wdf_q.pop_front();
          check("wdf_data", bus.wdf_din, e.data);
          check("wdf_mask", bus.wdf_mask_din, e.mask);
        end
      end
      if (bus.done) begin
        done_seen++;
        check("done_expected", done_expected > 0, 1'b1);
        if (done_expected > 0) done_expected--;
        check("af_drained_at_done", af_q.size(), 0);
        check("wdf_drained_at_done", wdf_q.size(), 0);
      end
    end
  end

  task automatic issue(input logic [23:0] col, input int x0, input int x1,
                       input int y0, input int y1, input logic [31:0] base);
    model_cmd(col, x0, x1, y0, y1, base);
    done_expected++;
    check("ready_before_accept", bus.ready, 1'b1);
    bus.color      = col;
    bus.x0         = 10'(x0);
    bus.x1         = 10'(x1);
    bus.y0         = 10'(y0);
    bus.y1         = 10'(y1);
    bus.frame_base = base;
    bus.valid      = 1'b1;
    @(posedge clk);
    #1;
    bus.valid      = 1'b0;
    bus.color      = 24'($urandom);
    bus.x0         = 10'($urandom);
    bus.x1         = 10'($urandom);
    bus.y0         = 10'($urandom);
    bus.y1         = 10'($urandom);
    bus.frame_base = $urandom;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    int n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_done_seen"}, done_seen != start, 1'b1);
    check({name, "_ready_after_done"}, bus.ready, 1'b1);
    check({name, "_done_single"}, bus.done, 1'b0);
  endtask

  int a0, w0;

  initial begin
    bus.valid = 1'b0;
    bus.color = '0;
    bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
    bus.frame_base = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_af_en", bus.af_wr_en, 1'b0);
    check("rst_wdf_en", bus.wdf_wr_en, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-width band, every mask zero
    a0 = af_pushes; w0 = wdf_pushes;
    issue(24'h123456, 0, 799, 0, 3, 32'h0000_0000);
    wait_done("band", 5000);
    check("band_af_count", af_pushes - a0, 400);
    check("band_wdf_count", wdf_pushes - w0, 800);

    // Unaligned edges on both sides
    a0 = af_pushes; w0 = wdf_pushes;
    issue(24'hA5C3F0, 3, 12, 5, 6, 32'h1000_0000);
    wait_done("unaligned", 200);
    check("unaligned_af_count", af_pushes - a0, 4);
    check("unaligned_wdf_count", wdf_pushes - w0, 8);

    // Bounds beyond the frame are clamped to the last burst
    a0 = af_pushes; w0 = wdf_pushes;
    issue(24'h00FF00, 792, 1000, 599, 900, 32'h2000_0000);
    wait_done("clamp", 200);
    check("clamp_af_count", af_pushes - a0, 1);
    check("clamp_wdf_count", wdf_pushes - w0, 2);

    // Empty rectangle: done right after accept, nothing written
    a0 = af_pushes; w0 = wdf_pushes;
    issue(24'h0000FF, 10, 9, 0, 0, 32'h0);
    check("empty_done_next", bus.done, 1'b1);
    wait_done("empty", 20);
    check("empty_af_count", af_pushes - a0, 0);
    check("empty_wdf_count", wdf_pushes - w0, 0);

    // 3x2 fill under random backpressure
    bp_mode = 1;
    a0 = af_pushes; w0 = wdf_pushes;
    issue(24'h777777, 5, 20, 10, 11, 32'h4008_0000);
    wait_done("bp", 500);
    check("bp_af_count", af_pushes - a0, 6);
    check("bp_ratio", (wdf_pushes - w0), 2 * (af_pushes - a0));

    // Random rectangles, some empty, some clamped, random backpressure
    for (int i = 0; i < 24; i++) begin
      int rx0, ry0;
      bp_mode = int'($urandom_range(0, 1));
      rx0 = int'($urandom_range(0, 830));
      ry0 = int'($urandom_range(0, 610));
      issue(24'($urandom), rx0, rx0 + int'($urandom_range(0, 40)) - 3,
            ry0, ry0 + int'($urandom_range(0, 3)) - 1, $urandom);
      wait_done("random", 2000);
    end
    bp_mode = 0;
    @(posedge clk);
    #1;

    // Reset while the second beat of a burst is pending
    begin
      int n;
      issue(24'hDEAD01, 0, 200, 0, 10, 32'h0);
      n = 0;
      @(negedge clk);
      while (!bus.af_wr_en && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("midrst_af_seen", bus.af_wr_en, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_ready", bus.ready, 1'b1);
      check("midrst_af_en", bus.af_wr_en, 1'b0);
      check("midrst_wdf_en", bus.wdf_wr_en, 1'b0);
      rst = 1'b0;
      af_q.delete();
      wdf_q.delete();
      done_expected = 0;
      @(posedge clk);
      #1;
      a0 = af_pushes; w0 = wdf_pushes;
      issue(24'h0BEEF0, 17, 30, 42, 43, 32'h3000_0000);
      wait_done("after_rst", 200);
      check("after_rst_af_count", af_pushes - a0, 4);
      check("after_rst_wdf_count", wdf_pushes - w0, 8);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rect_filler.md
Name: rect_filler

Overview:
- Parametrised successor to the full-frame filler: fills an arbitrary inclusive rectangle (x0..x1, y0..y1) of a frame buffer in DDR2 with one 24-bit colour.
- Writes go through the MIG address FIFO (af) and write-data FIFO (wdf).
- Each 8-pixel burst is one af command plus two 128-bit wdf beats. Byte masks cover unaligned left and right edges.
- Sits beside the graphics command processor, which issues fill commands through a valid/ready handshake.

Parameters:
- FRAME_W, 800, frame width in pixels; x1 is clamped to FRAME_W-1.
- FRAME_H, 600, frame height in pixels; y1 is clamped to FRAME_H-1.
- X_W, 10, pixel x coordinate width; burst index width XB_W = X_W-3.
- Y_W, 10, pixel y coordinate width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- valid  in  1  fill command offered
- ready  out  1  block idle, command accepted on valid&ready
- color  in  24  fill colour {R,G,B}, latched on accept
- x0, x1  in  X_W  inclusive column bounds, latched on accept
- y0, y1  in  Y_W  inclusive row bounds, latched on accept
- frame_base  in  32  frame buffer base, latched on accept
- af_full  in  1  address FIFO full
- wdf_full  in  1  write-data FIFO full
- af_wr_en  out  1  push af
- af_addr_din  out  31  burst address
- wdf_wr_en  out  1  push wdf
- wdf_din  out  128  four 32-bit pixels
- wdf_mask_din  out  16  byte mask, 1 = byte not written
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset values: ready=1, done=0, af_wr_en=0, wdf_wr_en=0, state IDLE. Data, address and mask outputs are don't-care while their enables are low.
- Reset mid-fill: return to IDLE next cycle. No further pushes; the partial fill is abandoned.
- Accept: in IDLE with valid=1, latch all inputs.
  - Clamp x1 to FRAME_W-1 and y1 to FRAME_H-1.
  - If x0>x1 or y0>y1 after clamping, go to DONE. The command writes nothing.
  - Otherwise set xb=x0[X_W-1:3], y=y0, and go to BEAT0.
- BEAT0:
  - When !af_full & !wdf_full, assert af_wr_en and wdf_wr_en in the same cycle (beat 0 = pixels xb*8+0..3), then go to BEAT1.
  - Otherwise hold with both enables low.
- BEAT1:
  - When !wdf_full, assert wdf_wr_en (beat 1 = pixels xb*8+4..7) and advance.
  - Otherwise hold with the enable low.
- Advance:
  - If xb < x1[X_W-1:3]: xb++, go to BEAT0.
  - Else if y < y1: y++, xb = x0[X_W-1:3], go to BEAT0.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. ready=1 only in IDLE.
- Throughput: one burst per 2 cycles with no backpressure. No bubbles between rows.
- af_addr_din = {frame_base[30:ADDR_LO], y, xb, 2'b00}, where ADDR_LO = Y_W+XB_W+2 (19 at defaults).
- wdf_din: pixel p (0..3) occupies bits [32p+31:32p] as {8'h00, color}. The lowest x is in the lowest lane.
- wdf_mask_din: bits [4p+3:4p] = 4'hF if that pixel's x < x0 or x > x1, else 4'h0. Interior beats carry mask 0.
- A beat that is entirely masked is still pushed, keeping two beats per af entry.
- valid while not ready is ignored. Inputs may change freely after acceptance.

Decomposition:
- Package rect_fill_pkg holds:
  - state encoding: IDLE, BEAT0, BEAT1, DONE
  - PIX_PER_BEAT=4, BEATS=2, BURST_PIX=8, PIXEL_PAD=8'h00
  - function computing ADDR_LO
- Sub-module rect_fill_mask: combinational. Inputs are the beat's first pixel x, x0 and x1; output is the 16-bit byte mask. It is instantiated once and fed the current beat's x.

Test Plan:
- Full frame, x0=0,x1=799,y0=0,y1=599, no backpressure -> 60000 af pushes, 120000 wdf pushes, all masks 0, one done pulse, ready high again the cycle after done.
- Unaligned rect, x0=3,x1=12,y0=5,y1=6, frame_base=32'h1000_0000 -> per row 2 bursts, beat masks 16'h0FFF, 16'h0000, 16'h0000, 16'hFFF0. First af_addr_din=31'h1000_0A00; third af_addr_din=31'h1000_0C00.
- Clamp, x0=792,x1=1000,y0=599,y1=900 -> exactly 1 af push and 2 wdf pushes, both masks 0, then done.
- Empty rect, x0=10,x1=9 -> no pushes, done pulses one cycle after accept.
- Backpressure: toggle af_full and wdf_full randomly during a 3x2 fill -> no enable asserted while its FIFO is full, af:wdf push ratio exactly 1:2, same address/data sequence as with no backpressure.
- Assert rst in BEAT1 mid-fill -> next cycle ready=1 and all enables 0. A new command then fills correctly from its own x0,y0.
